reg_alu_sequencer: RTL and testbench

Command-driven controller that sequences the 4-bit register block and shares the combinational ALU with it. It accepts one command per start/ready handshake and expands it into a train of single-cycle register control strobes: clear, load, repeated inc/dec, repeated shifts, or repeated register-accumulate through the ALU. When the command finishes it reports completion and the final register value. It sits between a host FSM or testbench and the existing register and ALU instances.

---
 rtl/reg_alu_sequencer_if.sv | 53 +++++
 rtl/reg_alu_sequencer.sv | 175 +++++++++++++++++
 tb/tb_reg_alu_sequencer.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/reg_alu_sequencer_if.sv
// Command and register/ALU bus between a host and reg_alu_sequencer.
// The slave modport is the sequencer's view and the master modport is the host/environment view.
// Command side: start/cmd/operand/count/fill/alu_op/abort in, and ready/busy/done/aborted/result out.
// Register/ALU side: control strobes, serial bits and reg_in out; reg_out in; alu_oc/alu_a/alu_b out; alu_f in.
interface reg_alu_sequencer_if #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 4
);
  // command request
  logic             start;
  logic [2:0]       cmd;
  logic [WIDTH-1:0] operand;
  logic [CNT_W-1:0] count;
  logic             fill;
  logic [2:0]       alu_op;
  logic             abort;
  // status / completion
  logic             ready;
  logic             busy;
  logic             done;
  logic             aborted;
  logic [WIDTH-1:0] result;
  // register block control
  logic             reg_cl;
  logic             reg_ld;
  logic             reg_inc;
  logic             reg_dec;
  logic             reg_sr;
  logic             reg_sl;
  logic             reg_ir;
  logic             reg_il;
  logic [WIDTH-1:0] reg_in;
  logic [WIDTH-1:0] reg_out;
  // shared ALU
  logic [2:0]       alu_oc;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [WIDTH-1:0] alu_f;

  modport slave (
    input  start, cmd, operand, count, fill, alu_op, abort, reg_out, alu_f,
    output ready, busy, done, aborted, result,
    output reg_cl, reg_ld, reg_inc, reg_dec, reg_sr, reg_sl, reg_ir, reg_il, reg_in,
    output alu_oc, alu_a, alu_b
  );

  modport master (
    output start, cmd, operand, count, fill, alu_op, abort, reg_out, alu_f,
    input  ready, busy, done, aborted, result,
    input  reg_cl, reg_ld, reg_inc, reg_dec, reg_sr, reg_sl, reg_ir, reg_il, reg_in,
    input  alu_oc, alu_a, alu_b
  );
endinterface

// File: rtl/reg_alu_sequencer.sv
// Command sequencer: expands one command into a train of single-cycle register strobes
// (clear, load, inc/dec, shift, or register-accumulate through the shared ALU).
// Latency: for a start accepted at edge k, the N strobes occupy cycles k+1..k+N and done is high in cycle k+N+1.
// Flow control: a start is only taken while ready=1; a start during EXEC/DONE is dropped, not queued.
// Ports: clk, rst (sync, active high); seq_if (slave modport) carries the command, status, register and ALU buses.
module reg_alu_sequencer #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  reg_alu_sequencer_if.slave   seq_if
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [2:0] C_NOP  = 3'd0;
  localparam logic [2:0] C_CLR  = 3'd1;
  localparam logic [2:0] C_LOAD = 3'd2;
  localparam logic [2:0] C_INC  = 3'd3;
  localparam logic [2:0] C_DEC  = 3'd4;
  localparam logic [2:0] C_SHR  = 3'd5;
  localparam logic [2:0] C_SHL  = 3'd6;
  localparam logic [2:0] C_ALU  = 3'd7;

  logic [1:0]       state_q,   state_d;
  logic [2:0]       cmd_q,     cmd_d;
  logic [WIDTH-1:0] operand_q, operand_d;
  logic [CNT_W-1:0] cnt_q,     cnt_d;      // iterations still to run
  logic             fill_q,    fill_d;
  logic [2:0]       alu_op_q,  alu_op_d;
  logic [WIDTH-1:0] result_q,  result_d;
  logic             aborted_q, aborted_d;

  logic             exec_en;

  // ---------------------------------------------------------------- next state
  always_comb begin
    state_d   = state_q;
    cmd_d     = cmd_q;
    operand_d = operand_q;
    cnt_d     = cnt_q;
    fill_d    = fill_q;
    alu_op_d  = alu_op_q;
    result_d  = result_q;
    aborted_d = aborted_q;

    case (state_q)
      S_IDLE: begin
        // abort is ignored here, so start+abort together still launches the command
        if (seq_if.start) begin
          cmd_d     = seq_if.cmd;
          operand_d = seq_if.operand;
          fill_d    = seq_if.fill;
          alu_op_d  = seq_if.alu_op;
          aborted_d = 1'b0;
          case (seq_if.cmd)
            C_NOP: begin
              cnt_d   = '0;
              state_d = S_DONE;
            end
            C_CLR, C_LOAD: begin
              cnt_d   = CNT_W'(1);
              state_d = S_EXEC;
            end
            default: begin
              // a repeat command with zero iterations completes without any strobe
              cnt_d   = seq_if.count;
              state_d = (seq_if.count == '0) ? S_DONE : S_EXEC;
            end
          endcase
        end
      end

      S_EXEC: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (seq_if.abort) begin
          aborted_d = 1'b1;
          state_d   = S_DONE;
        end else if (cnt_q == CNT_W'(1)) begin
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        // reg_out already reflects the last strobe's edge
        result_d = seq_if.reg_out;
        state_d  = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cmd_q     <= C_NOP;
      operand_q <= '0;
      cnt_q     <= '0;
      fill_q    <= 1'b0;
      alu_op_q  <= 3'd0;
      result_q  <= '0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cmd_q     <= cmd_d;
      operand_q <= operand_d;
      cnt_q     <= cnt_d;
      fill_q    <= fill_d;
      alu_op_q  <= alu_op_d;
      result_q  <= result_d;
      aborted_q <= aborted_d;
    end
  end

  // ---------------------------------------------------------------- status
  assign seq_if.ready   = (state_q == S_IDLE);
  assign seq_if.busy    = (state_q == S_EXEC);
  assign seq_if.done    = (state_q == S_DONE);
  assign seq_if.aborted = (state_q == S_DONE) && aborted_q;
  // during the done cycle the final value is presented directly so it is valid alongside done
  assign seq_if.result  = (state_q == S_DONE) ? seq_if.reg_out : result_q;

  // ---------------------------------------------------------------- strobes
  // abort and rst gate the strobe in the same cycle so the register never sees a
  // stray update on an aborted iteration or while being reset.
  assign exec_en = (state_q == S_EXEC) && !seq_if.abort && !rst;

  always_comb begin
    seq_if.reg_cl  = 1'b0;
    seq_if.reg_ld  = 1'b0;
    seq_if.reg_inc = 1'b0;
    seq_if.reg_dec = 1'b0;
    seq_if.reg_sr  = 1'b0;
    seq_if.reg_sl  = 1'b0;
    seq_if.reg_ir  = 1'b0;
    seq_if.reg_il  = 1'b0;
    seq_if.reg_in  = '0;
    if (exec_en) begin
      case (cmd_q)
        C_CLR:  seq_if.reg_cl = 1'b1;
        C_LOAD: begin
          seq_if.reg_ld = 1'b1;
          seq_if.reg_in = operand_q;
        end
        C_INC:  seq_if.reg_inc = 1'b1;
        C_DEC:  seq_if.reg_dec = 1'b1;
        C_SHR: begin
          seq_if.reg_sr = 1'b1;
          seq_if.reg_ir = fill_q;
        end
        C_SHL: begin
          seq_if.reg_sl = 1'b1;
          seq_if.reg_il = fill_q;
        end
        C_ALU: begin
          // register-accumulate: reg <= reg_out OP operand, once per iteration
          seq_if.reg_ld = 1'b1;
          seq_if.reg_in = seq_if.alu_f;
        end
        default: ;
      endcase
    end
  end

  // ALU operands: a always tracks the register so each iteration sees the updated value;
  // opcode and b hold the last latched command fields.
  assign seq_if.alu_oc = alu_op_q;
  assign seq_if.alu_a  = seq_if.reg_out;
  assign seq_if.alu_b  = operand_q;

endmodule

// File: tb/tb_reg_alu_sequencer.sv
module tb_reg_alu_sequencer;
  localparam int WIDTH = 4;
  localparam int CNT_W = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  reg_alu_sequencer_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) sif ();

  reg_alu_sequencer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk    (clk),
    .rst    (rst),
    .seq_if (sif)
  );

  int vectors = 0;
  int miscompares = 0;
  logic [3:0] exp_reg;

  // behavioural ALU used both as the environment's ALU and for expectations
  function automatic logic [3:0] alu_ref(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return a ^ b;
      3'd5: return ~a;
      3'd6: return a + 4'd1;
      default: return b;
    endcase
  endfunction

  // environment register block
  logic [3:0] reg_q;
  always @(posedge clk) begin
    if (rst)              reg_q <= 4'd0;
    else if (sif.reg_cl)  reg_q <= 4'd0;
    else if (sif.reg_ld)  reg_q <= sif.reg_in;
    else if (sif.reg_inc) reg_q <= reg_q + 4'd1;
    else if (sif.reg_dec) reg_q <= reg_q - 4'd1;
    else if (sif.reg_sr)  reg_q <= {sif.reg_ir, reg_q[3:1]};
    else if (sif.reg_sl)  reg_q <= {reg_q[2:0], sif.reg_il};
  end
  assign sif.reg_out = reg_q;
  assign sif.alu_f   = alu_ref(sif.alu_oc, sif.alu_a, sif.alu_b);

  // reference: value after applying command c n times, plain arithmetic
  function automatic logic [3:0] model_val(input logic [2:0] c, input logic [3:0] v0, input logic [3:0] opnd,
                                           input logic fl, input logic [2:0] aop, input int n);
    int v;
    v = int'(v0);
    for (int i = 0; i < n; i++) begin
      case (c)
        3'd1: v = 0;
        3'd2: v = int'(opnd);
        3'd3: v = (v + 1) % 16;
        3'd4: v = (v + 15) % 16;
        3'd5: v = (v / 2) + (fl ? 8 : 0);
        3'd6: v = ((v * 2) % 16) + (fl ? 1 : 0);
        3'd7: v = int'(alu_ref(aop, 4'(v), opnd));
        default: ;
      endcase
    end
    return 4'(v);
  endfunction

  function automatic logic [5:0] strobe_kind(input logic [2:0] c);
    case (c)
      3'd1:       return 6'b100000;
      3'd2, 3'd7: return 6'b010000;
      3'd3:       return 6'b001000;
      3'd4:       return 6'b000100;
      3'd5:       return 6'b000010;
      3'd6:       return 6'b000001;
      default:    return 6'b000000;
    endcase
  endfunction

  function automatic logic [5:0] strobes();
    return {sif.reg_cl, sif.reg_ld, sif.reg_inc, sif.reg_dec, sif.reg_sr, sif.reg_sl};
  endfunction

  // Runs one command. Entered and left at posedge+1 with the DUT idle.
  // abort_at: EXEC cycle (1-based) in which abort is raised, 0 for none.
  // noise: hold start high with scrambled fields during EXEC/DONE and raise abort in DONE.
  task automatic run_cmd(input logic [2:0] c, input logic [3:0] opnd, input logic [3:0] cnt,
                         input logic fl, input logic [2:0] aop, input int abort_at,
                         input bit noise, input string name);
    int n_iter, exec_cycles, n_strb, done_at;
    bit exp_ab, got_done;
    logic [5:0] kind, exp_s, s;
    logic [3:0] exp_val;

    n_iter = (c == 3'd0) ? 0 : (c <= 3'd2) ? 1 : int'(cnt);
    if (abort_at > 0 && abort_at <= n_iter) begin
      exec_cycles = abort_at; n_strb = abort_at - 1; exp_ab = 1'b1;
    end else begin
      exec_cycles = n_iter;   n_strb = n_iter;       exp_ab = 1'b0;
    end
    done_at = exec_cycles + 1;
    kind    = strobe_kind(c);
    exp_val = model_val(c, exp_reg, opnd, fl, aop, n_strb);

    vectors++;
    if (sif.ready !== 1'b1) begin
      miscompares++;
      $display("FAIL %s ready_before_start: got %b want 1", name, sif.ready);
    end
    sif.start = 1'b1; sif.cmd = c; sif.operand = opnd; sif.count = cnt;
    sif.fill = fl; sif.alu_op = aop; sif.abort = noise;
    got_done = 1'b0;

    for (int cyc = 1; cyc <= 40 && !got_done; cyc++) begin
      @(posedge clk); #1;
      // scramble inputs so only latched fields can produce correct strobes
      sif.start   = noise;
      sif.cmd     = 3'($urandom);
      sif.operand = 4'($urandom);
      sif.count   = 4'($urandom);
      sif.fill    = 1'($urandom);
      sif.alu_op  = 3'($urandom);
      sif.abort   = (cyc == abort_at) || (noise && cyc > exec_cycles);
      @(negedge clk);
      s     = strobes();
      exp_s = (cyc <= n_strb) ? kind : 6'b0;
      vectors++;
      if (s !== exp_s) begin
        miscompares++;
        $display("FAIL %s strobes cyc%0d: got %b want %b", name, cyc, s, exp_s);
      end
      vectors++;
      if (sif.busy !== (cyc <= exec_cycles)) begin
        miscompares++;
        $display("FAIL %s busy cyc%0d: got %b want %b", name, cyc, sif.busy, (cyc <= exec_cycles));
      end
      vectors++;
      if (sif.done !== (cyc == done_at)) begin
        miscompares++;
        $display("FAIL %s done cyc%0d: got %b want %b", name, cyc, sif.done, (cyc == done_at));
      end
      if (exp_s != 6'b0) begin
        vectors++;
        case (c)
          3'd2: if (sif.reg_in !== opnd) begin
            miscompares++;
            $display("FAIL %s load_data: got %h want %h", name, sif.reg_in, opnd);
          end
          3'd5: if (sif.reg_ir !== fl || sif.reg_il !== 1'b0) begin
            miscompares++;
            $display("FAIL %s shr_serial: got ir=%b il=%b want ir=%b il=0", name, sif.reg_ir, sif.reg_il, fl);
          end
          3'd6: if (sif.reg_il !== fl || sif.reg_ir !== 1'b0) begin
            miscompares++;
            $display("FAIL %s shl_serial: got il=%b ir=%b want il=%b ir=0", name, sif.reg_il, sif.reg_ir, fl);
          end
          3'd7: if (sif.reg_in !== alu_ref(aop, reg_q, opnd) || sif.alu_a !== reg_q ||
                    sif.alu_b !== opnd || sif.alu_oc !== aop) begin
            miscompares++;
            $display("FAIL %s alu_feed: got in=%h a=%h b=%h oc=%0d want in=%h a=%h b=%h oc=%0d", name,
                     sif.reg_in, sif.alu_a, sif.alu_b, sif.alu_oc, alu_ref(aop, reg_q, opnd), reg_q, opnd, aop);
          end
          default: if (sif.reg_in !== 4'd0) begin
            miscompares++;
            $display("FAIL %s reg_in_idle: got %h want 0", name, sif.reg_in);
          end
        endcase
      end else begin
        vectors++;
        if (sif.reg_in !== 4'd0 || sif.reg_ir !== 1'b0 || sif.reg_il !== 1'b0) begin
          miscompares++;
          $display("FAIL %s quiet_data cyc%0d: got in=%h ir=%b il=%b want 0", name, cyc, sif.reg_in, sif.reg_ir, sif.reg_il);
        end
      end
      if (sif.done === 1'b1) begin
        got_done = 1'b1;
        vectors++;
        if (sif.aborted !== exp_ab) begin
          miscompares++;
          $display("FAIL %s aborted: got %b want %b", name, sif.aborted, exp_ab);
        end
        vectors++;
        if (sif.result !== exp_val) begin
          miscompares++;
          $display("FAIL %s result: got %h want %h", name, sif.result, exp_val);
        end
      end
    end
    if (!got_done) begin
      miscompares++;
      $display("FAIL %s done_timeout: got no done want done at cycle %0d", name, done_at);
    end
    @(posedge clk); #1;
    sif.start = 1'b0; sif.abort = 1'b0;
    vectors++;
    if (sif.ready !== 1'b1 || sif.busy !== 1'b0 || sif.done !== 1'b0 || sif.result !== exp_val) begin
      miscompares++;
      $display("FAIL %s after_done: got rdy=%b busy=%b done=%b res=%h want 1 0 0 %h", name,
               sif.ready, sif.busy, sif.done, sif.result, exp_val);
    end
    exp_reg = exp_val;
  endtask

  task automatic check_reset_values(input string name);
    vectors++;
    if (sif.ready !== 1'b1 || sif.busy !== 1'b0 || sif.done !== 1'b0 || sif.aborted !== 1'b0 ||
        sif.result !== 4'd0 || strobes() !== 6'b0 || sif.reg_ir !== 1'b0 || sif.reg_il !== 1'b0 ||
        sif.reg_in !== 4'd0 || sif.alu_oc !== 3'd0 || sif.alu_a !== 4'd0 || sif.alu_b !== 4'd0) begin
      miscompares++;
      $display("FAIL %s reset_values: got rdy=%b busy=%b done=%b ab=%b res=%h strb=%b ir=%b il=%b in=%h oc=%0d a=%h b=%h",
               name, sif.ready, sif.busy, sif.done, sif.aborted, sif.result, strobes(), sif.reg_ir,
               sif.reg_il, sif.reg_in, sif.alu_oc, sif.alu_a, sif.alu_b);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    sif.start = 1'b1; sif.cmd = 3'd3; sif.operand = 4'h5; sif.count = 4'd4;
    sif.fill = 1'b1; sif.alu_op = 3'd2; sif.abort = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_values("power_on");
    sif.start = 1'b0;
    rst = 1'b0;
    exp_reg = 4'd0;
  endtask

  task automatic test_reset_mid_exec();
    bit saw_done;
    run_cmd(3'd2, 4'h9, 4'd0, 1'b0, 3'd0, 0, 1'b0, "preload");
    sif.start = 1'b1; sif.cmd = 3'd5; sif.count = 4'd8; sif.fill = 1'b1;
    @(posedge clk); #1;
    sif.start = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    vectors++;
    if (sif.reg_sr !== 1'b1) begin
      miscompares++;
      $display("FAIL shr_running: got reg_sr=%b want 1", sif.reg_sr);
    end
    rst = 1'b1; sif.start = 1'b1;
    #1;
    vectors++;
    if (strobes() !== 6'b0) begin
      miscompares++;
      $display("FAIL rst_gates_strobe: got %b want 000000", strobes());
    end
    @(posedge clk); #1;
    check_reset_values("mid_exec");
    rst = 1'b0; sif.start = 1'b0;
    exp_reg = 4'd0;
    saw_done = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (sif.done === 1'b1) saw_done = 1'b1;
    end
    vectors++;
    if (saw_done) begin
      miscompares++;
      $display("FAIL no_done_after_reset: got done want none");
    end
    @(posedge clk); #1;
    run_cmd(3'd2, 4'hA, 4'd0, 1'b0, 3'd0, 0, 1'b0, "load_after_reset");
  endtask

  task automatic test_inc_wrap();
    run_cmd(3'd2, 4'hE, 4'd0, 1'b0, 3'd0, 0, 1'b0, "load_e");
    run_cmd(3'd3, 4'h0, 4'd3, 1'b0, 3'd0, 0, 1'b0, "inc_wrap");
  endtask

  task automatic test_shift();
    run_cmd(3'd1, 4'h0, 4'd0, 1'b0, 3'd0, 0, 1'b0, "clr");
    run_cmd(3'd6, 4'h0, 4'd2, 1'b1, 3'd0, 0, 1'b0, "shl_fill1");
    run_cmd(3'd6, 4'h0, 4'd0, 1'b1, 3'd0, 0, 1'b0, "shl_count0");
    run_cmd(3'd5, 4'h0, 4'd3, 1'b0, 3'd0, 0, 1'b0, "shr_fill0");
  endtask

  task automatic test_alu();
    run_cmd(3'd2, 4'h1, 4'd0, 1'b0, 3'd0, 0, 1'b0, "alu_preload");
    run_cmd(3'd7, 4'h3, 4'd2, 1'b0, 3'd0, 0, 1'b0, "alu_add_x2");
    run_cmd(3'd7, 4'h6, 4'd3, 1'b0, 3'd4, 0, 1'b1, "alu_xor_x3");
  endtask

  task automatic test_abort();
    run_cmd(3'd2, 4'h7, 4'd0, 1'b0, 3'd0, 0, 1'b0, "abort_preload");
    run_cmd(3'd4, 4'h0, 4'd10, 1'b0, 3'd0, 4, 1'b1, "dec_abort4");
    run_cmd(3'd3, 4'h0, 4'd2, 1'b0, 3'd0, 1, 1'b0, "inc_abort1");
    run_cmd(3'd0, 4'h0, 4'd5, 1'b0, 3'd0, 0, 1'b1, "nop");
  endtask

  task automatic test_random();
    for (int i = 0; i < 30; i++) begin
      logic [2:0] c;
      int ab;
      c  = 3'($urandom);
      ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 8)) : 0;
      run_cmd(c, 4'($urandom), 4'($urandom_range(0, 7)), 1'($urandom), 3'($urandom),
              ab, 1'($urandom), "random");
    end
  endtask

  initial begin
    rst = 1'b1;
    sif.start = 1'b0; sif.cmd = 3'd0; sif.operand = 4'd0; sif.count = 4'd0;
    sif.fill = 1'b0; sif.alu_op = 3'd0; sif.abort = 1'b0;
    exp_reg = 4'd0;
    test_reset();
    test_reset_mid_exec();
    test_inc_wrap();
    test_shift();
    test_alu();
    test_abort();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
